// File: rtl/alu_pkg.sv
// Shared definitions for the handshaked ALU: opcode width and encodings,
// default data width and the controller state type.
package alu_pkg;

  localparam int ALUOP_W        = 4;
  localparam int DATA_WIDTH_DEF = 32;

  localparam logic [ALUOP_W-1:0] OP_AND  = 4'b0000;
  localparam logic [ALUOP_W-1:0] OP_OR   = 4'b0001;
  localparam logic [ALUOP_W-1:0] OP_ADD  = 4'b0010;
  localparam logic [ALUOP_W-1:0] OP_XOR  = 4'b0011;
  localparam logic [ALUOP_W-1:0] OP_NOR  = 4'b0100;
  localparam logic [ALUOP_W-1:0] OP_SLTU = 4'b0101;
  localparam logic [ALUOP_W-1:0] OP_SUB  = 4'b0110;
  localparam logic [ALUOP_W-1:0] OP_SLT  = 4'b0111;
  localparam logic [ALUOP_W-1:0] OP_SLL  = 4'b1000;
  localparam logic [ALUOP_W-1:0] OP_SRL  = 4'b1001;
  localparam logic [ALUOP_W-1:0] OP_SRA  = 4'b1010;
  localparam logic [ALUOP_W-1:0] OP_MUL  = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_hs_if.sv
// Handshake bundle between the decode stage (master) and the ALU (slave).
//   in_valid/in_ready  : op + operand transfer
//   A, B, ALUop        : operands and opcode
//   out_valid/out_ready: result slot handshake
//   Result, Overflow, CarryOut, Zero : registered result and flags
interface alu_hs_if
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] B;
  logic [ALUOP_W-1:0]    ALUop;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] Result;
  logic                  Overflow;
  logic                  CarryOut;
  logic                  Zero;

  modport master (
    output in_valid, A, B, ALUop, out_ready,
    input  in_ready, out_valid, Result, Overflow, CarryOut, Zero
  );

  modport slave (
    input  in_valid, A, B, ALUop, out_ready,
    output in_ready, out_valid, Result, Overflow, CarryOut, Zero
  );
endinterface

// File: rtl/alu_comb.sv
// Combinational ALU for all single-cycle ops (everything except MUL).
//   a, b      : operands; b[SHAMT_W-1:0] is the shift amount
//   op        : opcode; MUL and undefined codes give result 0, flags 0
//   result    : op result
//   overflow  : signed overflow, ADD/SUB only
//   carry_out : ADD carry out of MSB, SUB borrow (a < b unsigned)
module alu_comb
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [ALUOP_W-1:0]    op,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  overflow,
  output logic                  carry_out
);
  localparam int SHAMT_W = $clog2(DATA_WIDTH);

  logic                  is_sub;
  logic [DATA_WIDTH-1:0] b_eff;
  logic [DATA_WIDTH:0]   sum;
  logic [SHAMT_W-1:0]    shamt;
  logic                  ovf_raw;

  // SUB is A + ~B + 1; the extra top bit is carry (ADD) or not-borrow (SUB).
  assign is_sub  = (op == OP_SUB);
  assign b_eff   = is_sub ? ~b : b;
  assign sum     = {1'b0, a} + {1'b0, b_eff} + {{DATA_WIDTH{1'b0}}, is_sub};
  assign shamt   = b[SHAMT_W-1:0];
  assign ovf_raw = (a[DATA_WIDTH-1] == b_eff[DATA_WIDTH-1]) &&
                   (sum[DATA_WIDTH-1] != a[DATA_WIDTH-1]);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a signal unassigned and infers a latch.
    result    = '0;
    overflow  = 1'b0;
    carry_out = 1'b0;
    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOR:  result = ~(a | b);
      OP_ADD: begin
        result    = sum[DATA_WIDTH-1:0];
        overflow  = ovf_raw;
        carry_out = sum[DATA_WIDTH];
      end
      OP_SUB: begin
        result    = sum[DATA_WIDTH-1:0];
        overflow  = ovf_raw;
        carry_out = ~sum[DATA_WIDTH];
      end
      // A true signed compare, so the answer stays right when A-B overflows.
      OP_SLT:  result = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: result = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  result = a << shamt;
      OP_SRL:  result = a >> shamt;
      OP_SRA:  result = DATA_WIDTH'($signed(a) >>> shamt);
      default: result = '0;
    endcase
  end
endmodule

// File: rtl/alu_hs.sv
// Registered, handshaked ALU. Single-cycle ops produce a result one edge
// after accept; MUL runs a shift-add over DATA_WIDTH iteration edges.
//   clk    : system clock
//   resetn : asynchronous active-low reset, aborts any op in flight
//   bus    : alu_hs_if slave port (in/out valid-ready, operands, result, flags)
module alu_hs
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter bit MUL_EN     = 1'b1
) (
  input  logic   clk,
  input  logic   resetn,
  alu_hs_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

  alu_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic                  ovf_q, ovf_d;
  logic                  cout_q, cout_d;
  logic                  zero_q, zero_d;
  logic [DATA_WIDTH-1:0] mcand_q, mcand_d;   // A, shifted left each iteration
  logic [DATA_WIDTH-1:0] mplier_q, mplier_d; // B, bit 0 is the current bit
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0] comb_res;
  logic                  comb_ovf;
  logic                  comb_cout;
  logic [DATA_WIDTH-1:0] acc_sum;
  logic                  accept;
  logic                  is_mul;

  alu_comb #(.DATA_WIDTH(DATA_WIDTH)) u_comb (
    .a         (bus.A),
    .b         (bus.B),
    .op        (bus.ALUop),
    .result    (comb_res),
    .overflow  (comb_ovf),
    .carry_out (comb_cout)
  );

  // A new op may be taken in the same cycle the held result retires.
  assign bus.in_ready  = (state_q == ST_IDLE) ||
                         ((state_q == ST_HOLD) && bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  // With MUL_EN=0 the MUL code falls through to alu_comb as undefined.
  assign is_mul        = MUL_EN && (bus.ALUop == OP_MUL);
  assign acc_sum       = acc_q + (mplier_q[0] ? mcand_q : '0);

  assign bus.out_valid = (state_q == ST_HOLD);
  assign bus.Result    = res_q;
  assign bus.Overflow  = ovf_q;
  assign bus.CarryOut  = cout_q;
  assign bus.Zero      = zero_q;

  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    ovf_d    = ovf_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_MUL: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_HOLD;
          res_d   = acc_sum;
          ovf_d   = 1'b0;
          cout_d  = 1'b0;
          zero_d  = (acc_sum == '0);
        end
      end
      default: begin
        if ((state_q == ST_HOLD) && bus.out_ready) state_d = ST_IDLE;
        if (accept) begin
          if (is_mul) begin
            state_d  = ST_MUL;
            mcand_d  = bus.A;
            mplier_d = bus.B;
            acc_d    = '0;
            cnt_d    = CNT_W'(DATA_WIDTH);
          end else begin
            state_d = ST_HOLD;
            res_d   = comb_res;
            ovf_d   = comb_ovf;
            cout_d  = comb_cout;
            zero_d  = (comb_res == '0);
          end
        end
      end
    endcase
  end

  // NOTE: the multiplier datapath is reset along with the control state so
  // an aborted MUL leaves no partial product behind.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      res_q    <= res_d;
      ovf_q    <= ovf_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: tb/tb_alu_hs.sv
// Scoreboard bench for alu_hs: the driver pushes reference-model results on
// accept, a negedge monitor checks out_valid/in_ready timing and retired data.
module tb_alu_hs;
  import alu_pkg::*;

  localparam int DW = 32;
  localparam int SW = $clog2(DW);

  typedef struct {
    logic [DW-1:0] res;
    logic          ovf;
    logic          cout;
    logic          zero;
    int            ready_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  alu_hs_if #(.DATA_WIDTH(DW)) bus ();

  alu_hs #(.DATA_WIDTH(DW), .MUL_EN(1'b1)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  exp_t sb[$];
  bit   rand_bp = 1'b0;
  bit   ready_force = 1'b1;

  always @(posedge clk) cyc++;

  // Sole driver of out_ready: random backpressure or a directed level.
  always @(posedge clk) begin
    #1;
    bus.out_ready = rand_bp ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain integer arithmetic on the opcode definitions.
  function automatic exp_t model(logic [3:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
    exp_t          e;
    longint        sa, sb_, s;
    longint        max_s, min_s;
    logic [2*DW-1:0] p;
    logic [DW:0]   wide;
    int            sh;
    sa    = longint'($signed(a));
    sb_   = longint'($signed(b));
    max_s = (longint'(1) <<< (DW - 1)) - 1;
    min_s = -(longint'(1) <<< (DW - 1));
    sh    = int'(b[SW-1:0]);
    e.res = '0; e.ovf = 1'b0; e.cout = 1'b0; e.ready_cyc = 0;
    case (op)
      OP_AND:  e.res = a & b;
      OP_OR:   e.res = a | b;
      OP_XOR:  e.res = a ^ b;
      OP_NOR:  e.res = ~(a | b);
      OP_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        e.res  = wide[DW-1:0];
        e.cout = wide[DW];
        s      = sa + sb_;
        e.ovf  = (s > max_s) || (s < min_s);
      end
      OP_SUB: begin
        e.res  = a - b;
        e.cout = (a < b);
        s      = sa - sb_;
        e.ovf  = (s > max_s) || (s < min_s);
      end
      OP_SLT:  e.res = (sa < sb_) ? 1 : 0;
      OP_SLTU: e.res = (a < b) ? 1 : 0;
      OP_SLL:  e.res = a << sh;
      OP_SRL:  e.res = a >> sh;
      OP_SRA:  e.res = DW'(sa >>> sh);
      OP_MUL: begin
        p     = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
        e.res = p[DW-1:0];
      end
      default: e.res = '0;
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic issue(logic [3:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
    int   waited = 0;
    exp_t e;
    bus.in_valid = 1'b1;
    bus.ALUop    = op;
    bus.A        = a;
    bus.B        = b;
    @(negedge clk);
    while (!bus.in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    e = model(op, a, b);
    e.ready_cyc = cyc + ((op == OP_MUL) ? DW : 0);
    sb.push_back(e);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    while (sb.size() != 0 && waited < 500) begin
      @(posedge clk); #1;
      waited++;
    end
    check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: expected out_valid/in_ready derived from the scoreboard contents.
  always @(negedge clk) begin
    bit exp_ov;
    if (resetn) begin
      exp_ov = 1'b0;
      if (sb.size() != 0) exp_ov = (cyc >= sb[0].ready_cyc);
      check("out_valid", bus.out_valid, exp_ov);
      check("in_ready", bus.in_ready, (sb.size() == 0) || (exp_ov && bus.out_ready));
      if (bus.out_valid && exp_ov) begin
        check("Result",   bus.Result,   sb[0].res);
        check("Overflow", bus.Overflow, sb[0].ovf);
        check("CarryOut", bus.CarryOut, sb[0].cout);
        check("Zero",     bus.Zero,     sb[0].zero);
        if (bus.out_ready) void'(sb.pop_front());
      end
    end
  end

  function automatic logic [DW-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(DW-1){1'b0}}};
      3:       return {1'b0, {(DW-1){1'b1}}};
      4:       return DW'($urandom_range(0, 40));
      default: return DW'($urandom);
    endcase
  endfunction

  initial begin
    resetn       = 1'b0;
    bus.in_valid = 1'b0;
    bus.ALUop    = '0;
    bus.A        = '0;
    bus.B        = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_Result",    bus.Result,    '0);
    check("rst_Overflow",  bus.Overflow,  1'b0);
    check("rst_CarryOut",  bus.CarryOut,  1'b0);
    check("rst_Zero",      bus.Zero,      1'b0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Directed vectors; consecutive issues exercise accept-in-retire-cycle.
    issue(OP_ADD,  32'd1,          32'd1);
    issue(OP_ADD,  32'd88,         32'd5);
    issue(OP_ADD,  32'h7FFF_FFFF,  32'd1);
    issue(OP_ADD,  32'hFFFF_FFFF,  32'd1);
    issue(OP_SUB,  32'd111,        32'd111);
    issue(OP_SUB,  32'd1555,       32'd11111);
    issue(OP_SLT,  32'd1555,       32'd11111);
    issue(OP_SLT,  32'h8000_0000,  32'd1);
    issue(OP_SLTU, 32'hFFFF_FFFF,  32'd1);
    issue(OP_SRA,  32'h8000_0000,  32'd4);
    issue(OP_SLL,  32'd1,          32'h21);
    issue(OP_NOR,  32'h0F0F_0000,  32'h0000_F0F0);
    issue(OP_MUL,  32'd1555,       32'd11111);
    issue(OP_MUL,  32'hFFFF_FFFF,  32'hFFFF_FFFF);
    issue(4'b1110, 32'd7,          32'd9);
    drain();

    // Backpressure: result held for several cycles, then released.
    ready_force = 1'b0;
    issue(OP_XOR, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (6) begin
      @(posedge clk); #1;
    end
    ready_force = 1'b1;
    issue(OP_SUB, 32'd5, 32'd9);
    drain();

    // Randomised mix with random backpressure.
    rand_bp = 1'b1;
    for (int i = 0; i < 300; i++)
      issue(4'($urandom_range(0, 15)), pick_operand(), pick_operand());
    rand_bp = 1'b0;
    @(posedge clk); #1;
    drain();

    // Reset asserted partway through a MUL: outputs clear at once.
    issue(OP_ADD, 32'd40, 32'd2);
    issue(OP_MUL, 32'd1555, 32'd11111);
    repeat (9) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("abort_out_valid", bus.out_valid, 1'b0);
    check("abort_Result",    bus.Result,    '0);
    check("abort_Overflow",  bus.Overflow,  1'b0);
    check("abort_CarryOut",  bus.CarryOut,  1'b0);
    check("abort_Zero",      bus.Zero,      1'b0);
    sb.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    issue(4'b1111, 32'd123, 32'd456);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
